// File: rtl/shape_pkg.sv
// Shared types for the shape_processor command path: CTRL SFR layout,
// response status codes and sequencer FSM states.
package shape_pkg;

  typedef struct packed {
    logic [13:0] reserved1;
    logic [1:0]  shape;
    logic [10:0] reserved0;
    logic [4:0]  operation;
  } ctrl_sfr_reg;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_ERROR    = 2'd1,
    RSP_MISMATCH = 2'd2
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } seq_state_e;

  localparam int CMD_W = 7;

  function automatic ctrl_sfr_reg fmt_ctrl(input logic [1:0] shape, input logic [4:0] operation);
    ctrl_sfr_reg w;
    w           = '0;
    w.shape     = shape;
    w.operation = operation;
    return w;
  endfunction

endpackage

// File: rtl/shape_cmd_sequencer_if.sv
// Command, response and SFR signals of shape_cmd_sequencer.
// Handshakes: a transfer happens on the rising clk edge where valid && ready;
// the sender holds valid and its payload stable until that edge.
interface shape_cmd_sequencer_if #(
  parameter int LEVEL_W = 3
) ();
  import shape_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_shape;
  logic [4:0]         cmd_operation;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_status;
  logic [31:0]        rsp_ctrl;
  logic               write;
  logic [31:0]        write_data;
  logic               read;
  logic [31:0]        read_data;
  logic               error;
  logic               busy;
  logic [LEVEL_W-1:0] fifo_level;
  seq_state_e         state_dbg;

  modport slave (
    input  cmd_valid, cmd_shape, cmd_operation, rsp_ready, read_data, error,
    output cmd_ready, rsp_valid, rsp_status, rsp_ctrl, write, write_data, read,
           busy, fifo_level, state_dbg
  );

  modport master (
    output cmd_valid, cmd_shape, cmd_operation, rsp_ready, read_data, error,
    input  cmd_ready, rsp_valid, rsp_status, rsp_ctrl, write, write_data, read,
           busy, fifo_level, state_dbg
  );

endinterface

// File: rtl/shape_cmd_fifo.sv
// Registered synchronous FIFO with occupancy output; no write-to-read bypass.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module shape_cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 7,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LEVEL_W-1:0] wr_ptr;
  logic [LEVEL_W-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == LEVEL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Buffers (SHAPE, OPERATION) commands, writes each as a CTRL word to
// shape_processor, reads it back and reports OK / ERROR / MISMATCH.
module shape_cmd_sequencer
  import shape_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  shape_cmd_sequencer_if.slave   bus
);

  seq_state_e         state_q;
  seq_state_e         state_d;
  ctrl_sfr_reg        cmd_q;
  logic [1:0]         rsp_status_q;
  logic [31:0]        rsp_ctrl_q;
  logic [1:0]         status_d;
  ctrl_sfr_reg        rd_word;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   fifo_dout;
  logic [LEVEL_W-1:0] fifo_level;

  shape_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .WIDTH   (CMD_W),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid),
    .push_data ({bus.cmd_shape, bus.cmd_operation}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_WR;
        end
      end
      ST_WR:  state_d = ST_RD;
      ST_RD:  state_d = ST_RSP;
      ST_RSP: begin
        // Pop straight into WR on the handshake so queued commands run back-to-back.
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_WR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the SHAPE and OPERATION fields of the readback take part in the compare.
  always_comb begin
    rd_word = ctrl_sfr_reg'(bus.read_data);
    if (bus.error) begin
      status_d = RSP_ERROR;
    end else if ((rd_word.shape != cmd_q.shape) || (rd_word.operation != cmd_q.operation)) begin
      status_d = RSP_MISMATCH;
    end else begin
      status_d = RSP_OK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      rsp_status_q <= RSP_OK;
      rsp_ctrl_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) cmd_q <= fmt_ctrl(fifo_dout[6:5], fifo_dout[4:0]);
      if (state_q == ST_RD) begin
        rsp_status_q <= status_d;
        rsp_ctrl_q   <= bus.read_data;
      end
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.fifo_level = fifo_level;
  assign bus.write      = (state_q == ST_WR);
  assign bus.write_data = cmd_q;
  assign bus.read       = (state_q == ST_RD);
  assign bus.rsp_valid  = (state_q == ST_RSP);
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_ctrl   = rsp_ctrl_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Bench for shape_cmd_sequencer: directed scenarios plus random traffic,
// with a command queue, SFR responder model and response scoreboard.
`timescale 1ns/1ps
module tb_shape_cmd_sequencer;
  import shape_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shape_cmd_sequencer_if #(.LEVEL_W(LW)) bus ();

  shape_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [6:0]  cmd_q[$];
  logic [33:0] exp_q[$];
  int          model_level = 0;
  logic [6:0]  inflight = '0;
  logic        prev_write = 1'b0;
  logic        prev_read = 1'b0;
  logic        prev_stall = 1'b0;
  logic [33:0] stall_val = '0;
  logic        dir_en = 1'b0;
  logic [31:0] dir_data = '0;
  logic        dir_err = 1'b0;
  logic        gap_chk = 1'b0;
  logic        have_last = 1'b0;
  int          last_hs = 0;
  int          resp_count = 0;
  int          rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [6:0] c);
    logic [31:0] w;
    w        = 32'd0;
    w[17:16] = c[6:5];
    w[4:0]   = c[4:0];
    return w;
  endfunction

  function automatic logic [1:0] model_status(input logic [6:0] c, input logic [31:0] rd, input logic e);
    if (e) return 2'd1;
    if (rd[17:16] != c[6:5] || rd[4:0] != c[4:0]) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- rsp_ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rr_mode == 2) bus.rsp_ready = 1'($urandom_range(0, 1));
    else              bus.rsp_ready = (rr_mode == 1);
  end

  // ---------------- SFR responder + monitor ----------------
  always @(negedge clk) begin
    logic [31:0] rd;
    logic        e;
    int          r;
    if (rst) begin
      prev_write    = 1'b0;
      prev_read     = 1'b0;
      prev_stall    = 1'b0;
      bus.read_data = 32'd0;
      bus.error     = 1'b0;
    end else begin
      chk("wr_rd_exclusive", 64'(bus.write & bus.read), 64'd0);
      if (bus.write) begin
        if (cmd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_write: got write=1, expected no write (t=%0t)", $time);
        end else begin
          inflight = cmd_q.pop_front();
          model_level--;
          chk("write_data", 64'(bus.write_data), 64'(exp_word(inflight)));
        end
      end
      if (bus.read) begin
        chk("read_after_write", 64'(prev_write), 64'd1);
        if (dir_en) begin
          rd = dir_data; e = dir_err;
        end else begin
          r = $urandom_range(0, 3);
          rd = $urandom;
          e  = 1'b0;
          if (r < 2) rd = exp_word(inflight) | (rd & ~32'h0003_001F);
          else if (r == 3) e = 1'b1;
        end
        bus.read_data = rd;
        bus.error     = e;
        exp_q.push_back({model_status(inflight, rd, e), rd});
      end else begin
        bus.read_data = $urandom;
        bus.error     = 1'($urandom_range(0, 1));
      end
      if (prev_read) chk("rsp_after_read", 64'(bus.rsp_valid), 64'd1);
      if (prev_stall) begin
        chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_hold_payload", 64'({bus.rsp_status, bus.rsp_ctrl}), 64'(stall_val));
      end
      chk("fifo_level", 64'(bus.fifo_level), 64'(model_level));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(model_level < DEPTH));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_rsp: got status=%0d ctrl=%0h, expected none", bus.rsp_status, bus.rsp_ctrl);
        end else begin
          chk("rsp_status_ctrl", 64'({bus.rsp_status, bus.rsp_ctrl}), 64'(exp_q.pop_front()));
        end
        if (gap_chk && have_last) chk("rsp_gap", 64'(cyc - last_hs), 64'd3);
        last_hs   = cyc;
        have_last = 1'b1;
        resp_count++;
      end
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      stall_val  = {bus.rsp_status, bus.rsp_ctrl};
      prev_write = bus.write;
      prev_read  = bus.read;
      if (bus.cmd_valid && bus.cmd_ready) begin
        cmd_q.push_back({bus.cmd_shape, bus.cmd_operation});
        model_level++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] s, input logic [4:0] o);
    int budget = 0;
    bus.cmd_valid     = 1'b1;
    bus.cmd_shape     = s;
    bus.cmd_operation = o;
    @(negedge clk);
    while (!bus.cmd_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_ready) begin
      n_vec++; n_fail++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy || cmd_q.size() != 0 || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (bus.busy || cmd_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got busy=%0b pending=%0d, expected idle", name, bus.busy, exp_q.size() + cmd_q.size());
    end
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) begin
      n_vec++; n_fail++;
      $display("FAIL %s_rsp_timeout: got rsp_valid=0, expected 1", name);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish within 1ms");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int n;
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_shape     = '0;
    bus.cmd_operation = '0;
    repeat (3) @(negedge clk);
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_read", 64'(bus.read), 64'd0);
    chk("rst_write_data", 64'(bus.write_data), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    chk("rst_rsp_ctrl", 64'(bus.rsp_ctrl), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_fifo_level", 64'(bus.fifo_level), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Single command: latency and OK status.
    rr_mode  = 1;
    dir_en   = 1'b1;
    dir_data = 32'h0002_0005;
    dir_err  = 1'b0;
    @(posedge clk); #1;
    send_cmd(2'd2, 5'd5);
    @(negedge clk); chk("lat_n_no_write", 64'(bus.write), 64'd0);
    @(negedge clk); chk("lat_n1_write", 64'(bus.write), 64'd1);
    chk("lat_n1_write_data", 64'(bus.write_data), 64'h0002_0005);
    @(negedge clk); chk("lat_n2_read", 64'(bus.read), 64'd1);
    @(negedge clk); chk("lat_n3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("lat_n3_status", 64'(bus.rsp_status), 64'd0);
    chk("lat_n3_ctrl", 64'(bus.rsp_ctrl), 64'h0002_0005);
    wait_idle("single");
    chk("write_data_held", 64'(bus.write_data), 64'h0002_0005);

    // Mismatching readback, then error priority over mismatch.
    dir_data = 32'h0001_0005;
    send_cmd(2'd2, 5'd5);
    wait_idle("mismatch");
    dir_data = 32'h0003_0015;
    dir_err  = 1'b1;
    send_cmd(2'd2, 5'd5);
    wait_idle("error_prio");
    dir_en = 1'b0;

    // Five commands with rsp_ready low: FIFO fills, then drains 3 cycles apart.
    rr_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_cmd(2'(i), 5'(3 * i + 1));
    @(negedge clk);
    chk("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("full_level", 64'(bus.fifo_level), 64'd4);
    start     = resp_count;
    have_last = 1'b0;
    gap_chk   = 1'b1;
    rr_mode   = 1;
    n = 0;
    while (resp_count < start + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("five_rsp_count", 64'(resp_count - start), 64'd5);
    gap_chk = 1'b0;
    wait_idle("five");

    // Simultaneous push and pop at level 2.
    rr_mode = 0;
    @(posedge clk); #1;
    send_cmd(2'd1, 5'd9);
    send_cmd(2'd3, 5'd17);
    send_cmd(2'd0, 5'd30);
    wait_rsp_valid("simul");
    chk("simul_pre_level", 64'(bus.fifo_level), 64'd2);
    rr_mode = 1;
    @(posedge clk); #1;
    bus.cmd_valid     = 1'b1;
    bus.cmd_shape     = 2'd2;
    bus.cmd_operation = 5'd12;
    @(posedge clk);
    rr_mode = 0;
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("simul_level", 64'(bus.fifo_level), 64'd2);
    rr_mode = 1;
    wait_idle("simul");

    // Reset while in RD with 3 commands queued.
    rr_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_cmd(2'(3 - i), 5'(i + 20));
    wait_rsp_valid("rst_mid");
    rr_mode = 1;
    @(posedge clk);
    @(posedge clk);
    rr_mode = 0;
    n = 0;
    @(negedge clk);
    while (!bus.read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_in_read", 64'(bus.read), 64'd1);
    chk("rst_mid_queued", 64'(bus.fifo_level), 64'd3);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_read_drop", 64'(bus.read), 64'd0);
    chk("rst_mid_level", 64'(bus.fifo_level), 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    cmd_q.delete();
    exp_q.delete();
    model_level = 0;
    rr_mode     = 1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_mid_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Random traffic with random back-pressure and readback outcomes.
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end
    rr_mode = 1;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/shape_cmd_sequencer.md
Name: shape_cmd_sequencer

Overview:
- Upstream command stage for shape_processor.
- Accepts (SHAPE, OPERATION) commands over a valid/ready interface and buffers them in a small FIFO.
- For each command, issues one SFR write of the formatted CTRL word to shape_processor, then one readback.
- Returns a per-command status (OK / ERROR / MISMATCH) over a valid/ready response interface.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_shape  in  2  requested SHAPE
- cmd_operation  in  5  requested OPERATION
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_status  out  2  0=OK, 1=ERROR, 2=MISMATCH; 3 never driven
- rsp_ctrl  out  32  read_data captured during readback
- write  out  1  SFR write strobe to shape_processor
- write_data  out  32  CTRL word
- read  out  1  SFR read strobe to shape_processor
- read_data  in  32  CTRL readback; valid in the same cycle as read
- error  in  1  shape_processor error flag
- busy  out  1  FSM not in IDLE
- fifo_level  out  LEVEL_W  current FIFO occupancy

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - FSM in IDLE; FIFO empty; fifo_level=0.
  - write=0, read=0, write_data=0.
  - rsp_valid=0, rsp_status=0, rsp_ctrl=0, busy=0.
  - cmd_ready=1 once reset is released.
- CTRL word format: bits[17:16]=SHAPE, bits[4:0]=OPERATION, all other bits 0.
- FIFO:
  - Registered; cmd_ready = !full; no bypass path.
  - Push and pop in the same cycle is legal when not full; level is unchanged in that case.
  - When full, cmd_ready=0 and the offered command is not accepted.
- FSM states: IDLE, WR, RD, RSP.
  - IDLE: if FIFO non-empty, pop the head into a command register and go to WR; otherwise stay.
  - WR: write=1 for exactly one cycle; write_data = formatted word from the command register; go to RD.
  - RD: read=1 for exactly one cycle. Sample read_data into rsp_ctrl and sample error. Compute status:
    - error=1 → ERROR (ERROR has priority over MISMATCH).
    - else read_data[17:16]≠SHAPE or read_data[4:0]≠OPERATION → MISMATCH.
    - else OK.
    - Go to RSP.
  - RSP: rsp_valid=1 with status/ctrl held stable until rsp_ready. On handshake:
    - FIFO non-empty → pop the next command and go directly to WR (back-to-back).
    - FIFO empty → go to IDLE.
- write and read are never high in the same cycle; each is at most one cycle wide per command.
- write_data holds the last written word between commands (0 after reset).
- Latency: command accepted at edge N → write high in cycle N+1, read high in N+2, rsp_valid high from N+3.
- Back-to-back commands with rsp_ready held at 1: one command per 3 cycles.
- rsp_ready low stalls the FSM; the FIFO keeps accepting commands until full.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded; no response is produced for them.
- Readback bits other than [17:16] and [4:0] are ignored for comparison but are still captured in rsp_ctrl.

Decomposition:
- shape_pkg (shared package) holds:
  - ctrl_sfr_reg packed struct: reserved1[13:0], SHAPE[1:0], reserved0[10:0], OPERATION[4:0].
  - rsp_status_e enum: OK, ERROR, MISMATCH.
  - FSM state enum.
- Sub-module shape_cmd_fifo: generic synchronous FIFO, parameterised on DEPTH and WIDTH=7, with level output.
- The FSM and formatting logic stay in the top module.

Test Plan:
- Single command, SHAPE=2, OPERATION=5, readback echoes the write, error=0:
  - write_data=0x0002_0005 in cycle N+1; read in N+2; rsp_status=OK, rsp_ctrl=0x0002_0005 in N+3.
- Readback 0x0001_0005 for command SHAPE=2, OPERATION=5 → rsp_status=MISMATCH, rsp_ctrl=0x0001_0005.
- error=1 during RD with a mismatching readback → rsp_status=ERROR (priority check).
- Push 5 commands with FIFO_DEPTH=4 and rsp_ready=0:
  - First command is popped into the FSM; 4 more fill the FIFO; cmd_ready=0 with fifo_level=4.
  - After rsp_ready is raised, all 5 responses arrive in order, 3 cycles apart.
- Simultaneous push and pop at level 2 → level stays 2, and command order is preserved.
- Assert rst while FSM is in RD with 3 commands queued:
  - read drops immediately; fifo_level=0; busy=0.
  - No stale rsp_valid after rst is released.
